// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types and constants for the 6502 <-> PSRAM memory-controller bridge.
package cpu_mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        IO        = 3'd4
    } BridgeState;

    // 6510 on-chip processor port registers
    localparam logic [15:0] CPU_PORT_DDR  = 16'h0000;
    localparam logic [15:0] CPU_PORT_DATA = 16'h0001;

    // C64 banking bits of the processor port
    localparam int unsigned LORAM  = 0;
    localparam int unsigned HIRAM  = 1;
    localparam int unsigned CHAREN = 2;

endpackage

// File: rtl/cpu_mem_bridge_port.sv
// 6510 processor port: DDR at $0000, PORT at $0001, and the effective banking bits.
module cpu_port_6510
    import cpu_mem_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       reg_sel,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [2:0] port_eff
);

    logic [7:0] ddr_q;
    logic [7:0] port_q;

    // reg_sel: 0 selects DDR, 1 selects PORT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ddr_q  <= 8'h00;
            port_q <= 8'h00;
        end else if (wr_en) begin
            if (reg_sel) begin
                port_q <= wdata;
            end else begin
                ddr_q <= wdata;
            end
        end
    end

    assign rdata = reg_sel ? port_q : ddr_q;

    // Pins configured as inputs float high through the external pull-ups.
    always_comb begin
        port_eff         = 3'b000;
        port_eff[LORAM]  = (port_q[LORAM]  & ddr_q[LORAM])  | ~ddr_q[LORAM];
        port_eff[HIRAM]  = (port_q[HIRAM]  & ddr_q[HIRAM])  | ~ddr_q[HIRAM];
        port_eff[CHAREN] = (port_q[CHAREN] & ddr_q[CHAREN]) | ~ddr_q[CHAREN];
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Turns 6502 bus strobes into memCtrl transactions, stalling the CPU via RDY until done.
// Also decodes a zero-wait I/O window and hosts the 6510 processor port.
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter logic [3:0]  IO_NIBBLE      = 4'hD,
    parameter logic [5:0]  MEM_BANK       = 6'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cpu_strobe,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_dout,
    input  logic        i_cpu_we,
    output logic [7:0]  o_cpu_din,
    output logic        o_cpu_rdy,
    output logic        o_mem_ce,
    output logic        o_mem_write,
    output logic [5:0]  o_mem_bank,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_busy,
    input  logic        i_mem_data_ready,
    output logic        o_io_sel,
    output logic        o_io_we,
    output logic [11:0] o_io_addr,
    output logic [7:0]  o_io_wdata,
    input  logic [7:0]  i_io_rdata,
    output logic [2:0]  o_cpu_port,
    output logic        o_timeout,
    output logic [2:0]  o_state
);

    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    BridgeState state_q;
    BridgeState state_d;

    logic [7:0]           cpu_din_q;
    logic                 cpu_rdy_q;
    logic                 mem_write_q;
    logic [15:0]          mem_addr_q;
    logic [7:0]           mem_wdata_q;
    logic                 io_we_q;
    logic [11:0]          io_addr_q;
    logic [7:0]           io_wdata_q;
    logic                 timeout_q;
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic                 data_ready_q;

    logic       accept;
    logic       port_hit;
    logic       io_hit;
    logic       port_acc;
    logic       io_acc;
    logic       mem_acc;
    logic       wait_active;
    logic       dr_rise;
    logic       mem_done;
    logic       tmo_hit;
    logic       abort;
    logic       ce_fire;
    logic [7:0] port_rdata;

    // Strobes are only accepted in IDLE; everything else ignores them.
    assign accept   = (state_q == IDLE) && i_cpu_strobe;
    assign port_hit = (i_cpu_addr == CPU_PORT_DDR) || (i_cpu_addr == CPU_PORT_DATA);
    assign io_hit   = (i_cpu_addr[15:12] == IO_NIBBLE);
    assign port_acc = accept && port_hit;
    assign io_acc   = accept && !port_hit && io_hit;
    assign mem_acc  = accept && !port_hit && !io_hit;

    assign wait_active = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);
    assign dr_rise     = i_mem_data_ready && !data_ready_q;
    assign mem_done    = (state_q == WAIT_DONE) && (mem_write_q ? !i_mem_busy : dr_rise);
    assign tmo_hit     = wait_active && (tmo_cnt_q >= TMO_LIMIT);
    assign abort       = tmo_hit && !mem_done;
    assign ce_fire     = (state_q == ISSUE) && !i_mem_busy;

    cpu_port_6510 u_cpu_port (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (port_acc && i_cpu_we),
        .reg_sel  (i_cpu_addr[0]),
        .wdata    (i_cpu_dout),
        .rdata    (port_rdata),
        .port_eff (o_cpu_port)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (io_acc) begin
                    state_d = IO;
                end else if (mem_acc) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_mem_busy) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (i_mem_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mem_done || abort) begin
                    state_d = IDLE;
                end
            end
            IO: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_mem_ce   = ce_fire;
        o_io_sel   = (state_q == IO);
        o_state    = state_q;
        o_mem_bank = MEM_BANK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
        end else if (mem_acc) begin
            mem_write_q <= i_cpu_we;
            mem_addr_q  <= i_cpu_addr;
            mem_wdata_q <= i_cpu_dout;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_we_q    <= 1'b0;
            io_addr_q  <= 12'h000;
            io_wdata_q <= 8'h00;
        end else if (io_acc) begin
            io_we_q    <= i_cpu_we;
            io_addr_q  <= i_cpu_addr[11:0];
            io_wdata_q <= i_cpu_dout;
        end
    end

    // data_ready is a level; only its rising edge completes a read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= i_mem_data_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (ce_fire) begin
            tmo_cnt_q <= '0;
        end else if (wait_active && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (abort) begin
            timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdy_q <= 1'b1;
        end else if (mem_acc) begin
            cpu_rdy_q <= 1'b0;
        end else if (mem_done || abort) begin
            cpu_rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_din_q <= 8'hFF;
        end else if (port_acc && !i_cpu_we) begin
            cpu_din_q <= port_rdata;
        end else if ((state_q == IO) && !io_we_q) begin
            cpu_din_q <= i_io_rdata;
        end else if (mem_done && !mem_write_q) begin
            cpu_din_q <= i_mem_rdata;
        end else if (abort && !mem_write_q) begin
            cpu_din_q <= 8'hFF;
        end
    end

    assign o_cpu_din   = cpu_din_q;
    assign o_cpu_rdy   = cpu_rdy_q;
    assign o_mem_write = mem_write_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_io_we     = io_we_q;
    assign o_io_addr   = io_addr_q;
    assign o_io_wdata  = io_wdata_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge: expectations queued at stimulus time, popped by a monitor.
module tb_cpu_mem_bridge;

    logic        clk;
    logic        reset;
    logic        i_cpu_strobe;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_dout;
    logic        i_cpu_we;
    logic [7:0]  o_cpu_din;
    logic        o_cpu_rdy;
    logic        o_mem_ce;
    logic        o_mem_write;
    logic [5:0]  o_mem_bank;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic        i_mem_busy;
    logic        i_mem_data_ready;
    logic        o_io_sel;
    logic        o_io_we;
    logic [11:0] o_io_addr;
    logic [7:0]  o_io_wdata;
    logic [7:0]  i_io_rdata;
    logic [2:0]  o_cpu_port;
    logic        o_timeout;
    logic [2:0]  o_state;

    typedef struct { logic write; logic [15:0] addr; logic [7:0] wdata; } mem_exp_t;
    typedef struct { logic we; logic [11:0] addr; logic [7:0] wdata; } io_exp_t;
    typedef struct { logic chk_din; logic [7:0] din; logic tmo; } done_exp_t;

    mem_exp_t  exp_mem[$];
    io_exp_t   exp_io[$];
    done_exp_t exp_done[$];

    int n_checks = 0;
    int n_pass = 0;
    int rdy_low_cycles = 0;
    int rdy_low_snap = 0;
    int mem_mode = 0;  // 0: write-style busy, 1: read with data_ready, 2: never responds
    logic rdy_prev;

    cpu_mem_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .i_cpu_strobe     (i_cpu_strobe),
        .i_cpu_addr       (i_cpu_addr),
        .i_cpu_dout       (i_cpu_dout),
        .i_cpu_we         (i_cpu_we),
        .o_cpu_din        (o_cpu_din),
        .o_cpu_rdy        (o_cpu_rdy),
        .o_mem_ce         (o_mem_ce),
        .o_mem_write      (o_mem_write),
        .o_mem_bank       (o_mem_bank),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .i_mem_rdata      (i_mem_rdata),
        .i_mem_busy       (i_mem_busy),
        .i_mem_data_ready (i_mem_data_ready),
        .o_io_sel         (o_io_sel),
        .o_io_we          (o_io_we),
        .o_io_addr        (o_io_addr),
        .o_io_wdata       (o_io_wdata),
        .i_io_rdata       (i_io_rdata),
        .o_cpu_port       (o_cpu_port),
        .o_timeout        (o_timeout),
        .o_state          (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: got an unexpected pulse, expected none", name);
    endtask

    task automatic expect_mem(input logic w, input logic [15:0] a, input logic [7:0] d);
        mem_exp_t e;
        e.write = w; e.addr = a; e.wdata = d;
        exp_mem.push_back(e);
    endtask

    task automatic expect_io(input logic w, input logic [11:0] a, input logic [7:0] d);
        io_exp_t e;
        e.we = w; e.addr = a; e.wdata = d;
        exp_io.push_back(e);
    endtask

    task automatic expect_done(input logic chk, input logic [7:0] d, input logic t);
        done_exp_t e;
        e.chk_din = chk; e.din = d; e.tmo = t;
        exp_done.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that samples the strobe.
    task automatic cpu_strobe(input logic [15:0] a, input logic [7:0] d, input logic w);
        i_cpu_strobe = 1'b1;
        i_cpu_addr   = a;
        i_cpu_dout   = d;
        i_cpu_we     = w;
        @(posedge clk); #1;
        i_cpu_strobe = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_rdy(input string name, input int bound);
        int n = 0;
        while (!o_cpu_rdy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!o_cpu_rdy) begin
            n_checks++;
            $display("FAIL %s: rdy still low after %0d cycles, expected high", name, bound);
        end
    endtask

    // memCtrl model reacting to each ce pulse
    initial begin
        i_mem_busy = 1'b0;
        i_mem_data_ready = 1'b0;
        i_mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (o_mem_ce && mem_mode != 2) begin
                repeat (2) @(posedge clk);
                #1 i_mem_busy = 1'b1;
                if (mem_mode == 0) begin
                    repeat (5) @(posedge clk);
                    #1 i_mem_busy = 1'b0;
                end else begin
                    repeat (4) @(posedge clk);
                    #1;
                    i_mem_rdata = 8'h14;
                    i_mem_data_ready = 1'b1;
                    i_mem_busy = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 i_mem_data_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a ce, an io_sel or a rising RDY.
    initial begin
        mem_exp_t  m;
        io_exp_t   io;
        done_exp_t dn;
        rdy_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (o_mem_ce) begin
                if (exp_mem.size() == 0) begin
                    unexpected("mem_ce");
                end else begin
                    m = exp_mem.pop_front();
                    check("ce_write", {31'd0, o_mem_write}, {31'd0, m.write});
                    check("ce_addr", {16'd0, o_mem_addr}, {16'd0, m.addr});
                    check("ce_wdata", {24'd0, o_mem_wdata}, {24'd0, m.wdata});
                end
            end
            if (o_io_sel) begin
                if (exp_io.size() == 0) begin
                    unexpected("io_sel");
                end else begin
                    io = exp_io.pop_front();
                    check("io_we", {31'd0, o_io_we}, {31'd0, io.we});
                    check("io_addr", {20'd0, o_io_addr}, {20'd0, io.addr});
                    if (io.we) check("io_wdata", {24'd0, o_io_wdata}, {24'd0, io.wdata});
                end
            end
            if (!o_cpu_rdy) rdy_low_cycles++;
            if (o_cpu_rdy && !rdy_prev) begin
                if (exp_done.size() == 0) begin
                    unexpected("rdy_rise");
                end else begin
                    dn = exp_done.pop_front();
                    if (dn.chk_din) check("done_din", {24'd0, o_cpu_din}, {24'd0, dn.din});
                    check("done_timeout", {31'd0, o_timeout}, {31'd0, dn.tmo});
                end
            end
            rdy_prev = o_cpu_rdy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        i_cpu_strobe = 1'b0;
        i_cpu_addr = 16'h0000;
        i_cpu_dout = 8'h00;
        i_cpu_we = 1'b0;
        i_io_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

        check("rst_rdy", {31'd0, o_cpu_rdy}, 32'd1);
        check("rst_din", {24'd0, o_cpu_din}, 32'hFF);
        check("rst_port", {29'd0, o_cpu_port}, 32'd7);
        check("rst_state", {29'd0, o_state}, 32'd0);
        check("rst_ce", {31'd0, o_mem_ce}, 32'd0);
        check("rst_timeout", {31'd0, o_timeout}, 32'd0);
        check("rst_mem_addr", {16'd0, o_mem_addr}, 32'd0);
        check("rst_bank", {26'd0, o_mem_bank}, 32'd0);
        step();

        // RAM write
        mem_mode = 0;
        expect_mem(1'b1, 16'hC000, 8'h79);
        expect_done(1'b0, 8'h00, 1'b0);
        cpu_strobe(16'hC000, 8'h79, 1'b1);
        check("wr_rdy_low", {31'd0, o_cpu_rdy}, 32'd0);
        wait_rdy("wr_done", 50);
        step();

        // RAM read
        mem_mode = 1;
        expect_mem(1'b0, 16'hC000, 8'h00);
        expect_done(1'b1, 8'h14, 1'b0);
        cpu_strobe(16'hC000, 8'h00, 1'b0);
        check("rd_rdy_low", {31'd0, o_cpu_rdy}, 32'd0);
        wait_rdy("rd_done", 50);
        check("rd_din", {24'd0, o_cpu_din}, 32'h14);
        step();
        check("rd_state_idle", {29'd0, o_state}, 32'd0);

        // I/O window
        rdy_low_snap = rdy_low_cycles;
        expect_io(1'b1, 12'h020, 8'h05);
        cpu_strobe(16'hD020, 8'h05, 1'b1);
        step();
        i_io_rdata = 8'h0E;
        expect_io(1'b0, 12'h020, 8'h00);
        cpu_strobe(16'hD020, 8'h00, 1'b0);
        step();
        check("io_rd_din", {24'd0, o_cpu_din}, 32'h0E);

        // 6510 processor port
        cpu_strobe(16'h0000, 8'h2F, 1'b1);
        cpu_strobe(16'h0001, 8'h35, 1'b1);
        cpu_strobe(16'h0001, 8'h00, 1'b0);
        check("port_eff", {29'd0, o_cpu_port}, 32'd5);
        check("port_din", {24'd0, o_cpu_din}, 32'h35);
        cpu_strobe(16'h0000, 8'h00, 1'b0);
        check("ddr_din", {24'd0, o_cpu_din}, 32'h2F);
        check("zero_wait_rdy", rdy_low_cycles, rdy_low_snap);
        step();

        // Timeout with a strobe issued while stalled
        mem_mode = 2;
        expect_mem(1'b0, 16'h8000, 8'h00);
        expect_done(1'b1, 8'hFF, 1'b1);
        cpu_strobe(16'h8000, 8'h00, 1'b0);
        cpu_strobe(16'h1234, 8'hAA, 1'b1);
        check("stall_addr_kept", {16'd0, o_mem_addr}, 32'h8000);
        check("stall_write_kept", {31'd0, o_mem_write}, 32'd0);
        wait_rdy("tmo_abort", 400);
        check("tmo_flag", {31'd0, o_timeout}, 32'd1);
        check("tmo_din", {24'd0, o_cpu_din}, 32'hFF);
        check("tmo_rdy", {31'd0, o_cpu_rdy}, 32'd1);
        step();
        check("tmo_state_idle", {29'd0, o_state}, 32'd0);
        check("tmo_flag_sticky", {31'd0, o_timeout}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_clears_timeout", {31'd0, o_timeout}, 32'd0);
        step();
        reset = 1'b1;
        repeat (3) step();

        check("mem_queue_drained", exp_mem.size(), 32'd0);
        check("io_queue_drained", exp_io.size(), 32'd0);
        check("done_queue_drained", exp_done.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
